// File: rtl/oc7_in_pkg.sv
// Shared widths, count type and the gate-level equation helpers for the
// seven-input ones counter.
package oc7_in_pkg;

    localparam int unsigned COUNT_W = 3;
    localparam int unsigned N_IN    = 7;

    typedef logic [COUNT_W-1:0] count_t;

    // Count bit 1 equals the parity of all pairwise ANDs, since C(k,2) is odd exactly for k mod 4 in {2,3}
    function automatic logic pair_parity(input logic [N_IN-1:0] v);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            for (int unsigned j = i + 1; j < N_IN; j++) begin
                p = p ^ (v[i] & v[j]);
            end
        end
        return p;
    endfunction

    // Count bit 2: at least four inputs high, as an OR of every 4-input AND term
    function automatic logic quad_any(input logic [N_IN-1:0] v);
        logic q;
        q = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            for (int unsigned j = i + 1; j < N_IN; j++) begin
                for (int unsigned k = j + 1; k < N_IN; k++) begin
                    for (int unsigned l = k + 1; l < N_IN; l++) begin
                        q = q | (v[i] & v[j] & v[k] & v[l]);
                    end
                end
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/oc7_in_if.sv
// Signal bundle for the seven-input ones counter: seven count inputs,
// the registered 3-bit count and the self-check flag.
interface oc7_in_if;

    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic y0;
    logic y1;
    logic y2;
    logic mismatch;

    modport master (
        output a, b, c, d, e, f, g,
        input  y0, y1, y2, mismatch
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        output y0, y1, y2, mismatch
    );

endinterface

// File: rtl/oc7_in_full_adder.sv
// One-bit full adder used to build the structural count path.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/oc7_in.sv
// Registered 7-input popcount with a self-check flag comparing an adder-tree
// count against a flat equation count.
module oc7_in
    import oc7_in_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    oc7_in_if.slave  bus
);

    logic [N_IN-1:0] w_in;
    logic            w_s1, w_c1, w_s2, w_c2, w_c3;
    logic            w_n0, w_n1, w_n2;
    logic            w_q0, w_q1, w_q2;
    count_t          w_n;
    count_t          w_q;
    count_t          r_y;
    logic            r_mismatch;

    assign w_in = {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};

    // Structural path: two 3:2 compressors, then weight-1 and weight-2 columns
    full_adder u_fa1 (.x(bus.a), .y(bus.b), .ci(bus.c), .s(w_s1), .co(w_c1));
    full_adder u_fa2 (.x(bus.d), .y(bus.e), .ci(bus.f), .s(w_s2), .co(w_c2));
    full_adder u_fa3 (.x(w_s1),  .y(w_s2),  .ci(bus.g), .s(w_n0), .co(w_c3));
    full_adder u_fa4 (.x(w_c1),  .y(w_c2),  .ci(w_c3),  .s(w_n1), .co(w_n2));

    assign w_n = {w_n2, w_n1, w_n0};

    assign w_q0 = ^w_in;
    assign w_q1 = pair_parity(w_in);
    assign w_q2 = quad_any(w_in);
    assign w_q  = {w_q2, w_q1, w_q0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y        <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_y        <= w_n;
            r_mismatch <= (w_n != w_q);
        end
    end

    assign bus.y0       = r_y[0];
    assign bus.y1       = r_y[1];
    assign bus.y2       = r_y[2];
    assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_oc7_in.sv
// Directed and random checks of the registered 7-input ones counter against
// a plain-arithmetic popcount model.
module tb_oc7_in;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    oc7_in_if bus ();

    oc7_in u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pattern bit 6 is input a, bit 0 is input g (matches "a b c d e f g" listings)
    task automatic apply(input logic [6:0] pat);
        bus.a = pat[6];
        bus.b = pat[5];
        bus.c = pat[4];
        bus.d = pat[3];
        bus.e = pat[2];
        bus.f = pat[1];
        bus.g = pat[0];
    endtask

    function automatic int popcount(input logic [6:0] pat);
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) n = n + int'(pat[i]);
        return n;
    endfunction

    function automatic logic [3:0] observed();
        return {bus.mismatch, bus.y2, bus.y1, bus.y0};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed={mm,y}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One sample per cycle: drive after the falling edge, check just after the capturing edge
    task automatic step(input string tag, input logic [6:0] pat);
        @(negedge clk);
        apply(pat);
        @(posedge clk);
        #1;
        check(tag, observed(), {1'b0, 3'(popcount(pat))});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        apply(7'($urandom));

        // Held reset with random inputs and a running clock
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            apply(7'($urandom));
            #1;
            check("reset_hold_mid", observed(), 4'b0000);
            @(posedge clk);
            #1;
            check("reset_hold_edge", observed(), 4'b0000);
        end

        // Release: first edge with rst_n=1 loads the present inputs
        @(negedge clk);
        rst_n = 1'b1;
        apply(7'b0000001);
        @(posedge clk);
        #1;
        check("release_0000001", observed(), 4'b0001);

        step("basic_0000011", 7'b0000011);
        check("basic_0000011_abs", observed(), 4'b0010);
        step("basic_0011110", 7'b0011110);
        check("basic_0011110_abs", observed(), 4'b0100);

        step("ext_0000000", 7'b0000000);
        check("ext_0000000_abs", observed(), 4'b0000);
        step("ext_1111111", 7'b1111111);
        check("ext_1111111_abs", observed(), 4'b0111);
        step("ext_1010101", 7'b1010101);
        check("ext_1010101_abs", observed(), 4'b0100);
        step("ext_0101010", 7'b0101010);
        check("ext_0101010_abs", observed(), 4'b0011);

        // Asynchronous assertion between edges clears without a clock edge
        @(negedge clk);
        apply(7'b1111111);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clear", observed(), 4'b0000);
        @(posedge clk);
        #1;
        check("async_hold", observed(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(7'b0110100);
        @(posedge clk);
        #1;
        check("async_release", observed(), 4'b0011);

        for (int i = 0; i < 40; i++) begin
            step("random", 7'($urandom));
        end

        for (int p = 0; p < 128; p++) begin
            step("sweep", 7'(p));
        end

        // Mid-stream reset: pending all-ones sample is discarded
        @(negedge clk);
        apply(7'b1111111);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_clear", observed(), 4'b0000);
        @(posedge clk);
        #1;
        check("mid_reset_discard", observed(), 4'b0000);
        @(negedge clk);
        apply(7'b0000011);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_release", observed(), 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
